// File: rtl/alu_driver_if.sv
// Request, response and ALU-side signal bundle for alu_driver.
// The slave modport is the driver itself; master is the surrounding datapath plus the ALU.
interface alu_driver_if;
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqOp;
  logic [63:0] reqA;
  logic [63:0] reqB;
  logic [3:0]  reqTag;

  logic [63:0] aluFirst;
  logic [63:0] aluSecond;
  logic [3:0]  aluOp;
  logic [63:0] aluResult;
  logic        aluCarry;

  logic        rspValid;
  logic        rspReady;
  logic [63:0] rspData;
  logic        rspCarry;
  logic [3:0]  rspTag;
  logic        rspError;

  logic [15:0] opCount;
  logic [7:0]  errCount;

  modport master (
    output reqValid, reqOp, reqA, reqB, reqTag, rspReady, aluResult, aluCarry,
    input  reqReady, aluFirst, aluSecond, aluOp,
    input  rspValid, rspData, rspCarry, rspTag, rspError, opCount, errCount
  );

  modport slave (
    input  reqValid, reqOp, reqA, reqB, reqTag, rspReady, aluResult, aluCarry,
    output reqReady, aluFirst, aluSecond, aluOp,
    output rspValid, rspData, rspCarry, rspTag, rspError, opCount, errCount
  );
endinterface

// File: rtl/alu_driver.sv
// Buffers ALU requests in a FIFO, drives the combinational ALU, waits a settle interval and returns results in order.
// Optional response statistics counters are built when ALU_DRV_STATS_EN is defined.
module alu_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic         clk,
  input logic         rstN,
  alu_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
  } req_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  req_t             mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wrPtr_q, rdPtr_q;
  logic             full, empty, push, pop;
  req_t             head;
  logic             headLegal, headErr;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       heldTag_q, heldTag_d;
  logic [63:0]      aluFirst_q, aluFirst_d, aluSecond_q, aluSecond_d;
  logic [3:0]       aluOp_q, aluOp_d;
  logic [63:0]      rspData_q, rspData_d;
  logic             rspCarry_q, rspCarry_d, rspError_q, rspError_d;
  logic [3:0]       rspTag_q, rspTag_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                 (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign push  = bus.reqValid && !full;
  assign head  = mem_q[rdPtr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[PTR_W-1:0]] <= {bus.reqOp, bus.reqA, bus.reqB, bus.reqTag};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
      if (pop)  rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    headLegal = 1'b0;
    case (head.op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1100: headLegal = 1'b1;
      default:                            headLegal = 1'b0;
    endcase
  end

  assign headErr = !headLegal || ((head.op == 4'b0011) && (head.b == '0));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      heldTag_q   <= '0;
      aluFirst_q  <= '0;
      aluSecond_q <= '0;
      aluOp_q     <= '0;
      rspData_q   <= '0;
      rspCarry_q  <= 1'b0;
      rspError_q  <= 1'b0;
      rspTag_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      heldTag_q   <= heldTag_d;
      aluFirst_q  <= aluFirst_d;
      aluSecond_q <= aluSecond_d;
      aluOp_q     <= aluOp_d;
      rspData_q   <= rspData_d;
      rspCarry_q  <= rspCarry_d;
      rspError_q  <= rspError_d;
      rspTag_q    <= rspTag_d;
    end
  end

  // A pop is taken from IDLE or on the response handshake, so back-to-back requests lose no cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    heldTag_d   = heldTag_q;
    aluFirst_d  = aluFirst_q;
    aluSecond_d = aluSecond_q;
    aluOp_d     = aluOp_q;
    rspData_d   = rspData_q;
    rspCarry_d  = rspCarry_q;
    rspError_d  = rspError_q;
    rspTag_d    = rspTag_q;
    pop         = 1'b0;

    case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d      = '0;
          rspData_d  = bus.aluResult;
          rspCarry_d = (aluOp_q == 4'b0000) && bus.aluCarry;
          rspError_d = 1'b0;
          rspTag_d   = heldTag_q;
          state_d    = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: if (bus.rspReady) state_d = IDLE;
      default: ;
    endcase

    if (!empty && ((state_q == IDLE) || ((state_q == RESPOND) && bus.rspReady))) begin
      pop = 1'b1;
      if (headErr) begin
        rspData_d  = '0;
        rspCarry_d = 1'b0;
        rspError_d = 1'b1;
        rspTag_d   = head.tag;
        state_d    = RESPOND;
      end else begin
        aluFirst_d  = head.a;
        aluSecond_d = head.b;
        aluOp_d     = head.op;
        heldTag_d   = head.tag;
        cnt_d       = CNT_W'(SETTLE_CYCLES);
        state_d     = SETTLE;
      end
    end
  end

  assign bus.reqReady  = !full;
  assign bus.aluFirst  = aluFirst_q;
  assign bus.aluSecond = aluSecond_q;
  assign bus.aluOp     = aluOp_q;
  assign bus.rspValid  = (state_q == RESPOND);
  assign bus.rspData   = rspData_q;
  assign bus.rspCarry  = rspCarry_q;
  assign bus.rspTag    = rspTag_q;
  assign bus.rspError  = rspError_q;

`ifdef ALU_DRV_STATS_EN
  logic [15:0] opCount_q;
  logic [7:0]  errCount_q;
  logic        rspFire;

  assign rspFire = (state_q == RESPOND) && bus.rspReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opCount_q  <= '0;
      errCount_q <= '0;
    end else if (rspFire) begin
      if (opCount_q != 16'hFFFF) opCount_q <= opCount_q + 16'd1;
      if (rspError_q && (errCount_q != 8'hFF)) errCount_q <= errCount_q + 8'd1;
    end
  end

  assign bus.opCount  = opCount_q;
  assign bus.errCount = errCount_q;
`else
  assign bus.opCount  = '0;
  assign bus.errCount = '0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard testbench for alu_driver: directed scenarios plus randomized traffic against a reference model.
// Includes a behavioural stand-in for the 64-bit ALU the driver controls.
module tb_alu_driver;
  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [63:0] data;
    logic        carry;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rstN;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   acceptCyc  = 0;
  int   hsCount    = 0;
  int   errHs      = 0;
  bit   randReady  = 1'b0;
  bit   fixedReady = 1'b1;
  rsp_t sb[$];

  alu_driver_if bus ();

  alu_driver #(.SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in; non-add carry is deliberately noisy so the driver must mask it.
  always_comb begin
    bus.aluResult = 64'hDEAD_BEEF_0BAD_F00D;
    bus.aluCarry  = ^bus.aluFirst;
    case (bus.aluOp)
      4'b0000: {bus.aluCarry, bus.aluResult} = {1'b0, bus.aluFirst} + {1'b0, bus.aluSecond};
      4'b0001: begin
        bus.aluResult = bus.aluFirst - bus.aluSecond;
        bus.aluCarry  = bus.aluFirst < bus.aluSecond;
      end
      4'b0010: bus.aluResult = bus.aluFirst * bus.aluSecond;
      4'b0011: bus.aluResult = (bus.aluSecond == 0) ? 64'd0 : bus.aluFirst / bus.aluSecond;
      4'b0111: bus.aluResult = bus.aluSecond;
      4'b1000: bus.aluResult = bus.aluFirst & bus.aluSecond;
      4'b1001: bus.aluResult = bus.aluFirst | bus.aluSecond;
      4'b1010: bus.aluResult = bus.aluFirst ^ bus.aluSecond;
      4'b1100: bus.aluResult = ~(bus.aluFirst | bus.aluSecond);
      default: ;
    endcase
  end

  function automatic rsp_t refModel(logic [3:0] op, logic [63:0] a, logic [63:0] b, logic [3:0] tag);
    rsp_t r;
    r.data  = 64'd0;
    r.carry = 1'b0;
    r.err   = 1'b0;
    r.tag   = tag;
    case (op)
      4'd0:    {r.carry, r.data} = {1'b0, a} + {1'b0, b};
      4'd1:    r.data = a - b;
      4'd2:    r.data = a * b;
      4'd3:    if (b == 0) r.err = 1'b1; else r.data = a / b;
      4'd7:    r.data = b;
      4'd8:    r.data = a & b;
      4'd9:    r.data = a | b;
      4'd10:   r.data = a ^ b;
      4'd12:   r.data = ~(a | b);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failBound(string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic applyStimulus(logic [3:0] op, logic [63:0] a, logic [63:0] b, logic [3:0] tag);
    bit ok = 1'b0;
    @(negedge clk);
    bus.reqOp    = op;
    bus.reqA     = a;
    bus.reqB     = b;
    bus.reqTag   = tag;
    bus.reqValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.reqReady) begin
        acceptCyc = cyc + 1;
        @(posedge clk);
        sb.push_back(refModel(op, a, b, tag));
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 bus.reqValid = 1'b0;
    if (!ok) failBound("pushTimeout");
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rspValid) begin
        lat = cyc - acceptCyc;
        break;
      end
    end
    if (lat < 0) failBound("rspValidTimeout");
  endtask

  task automatic drain(int maxCyc);
    bit done = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rspValid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) failBound("drainTimeout");
  endtask

  task automatic assertReset();
    @(posedge clk);
    #2 rstN = 1'b0;
    sb.delete();
    hsCount = 0;
    errHs   = 0;
    #1;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2 rstN = 1'b1;
  endtask

  initial begin
    bus.rspReady = 1'b0;
    forever begin
      @(posedge clk);
      #2 bus.rspReady = randReady ? ($urandom_range(0, 3) != 0) : fixedReady;
    end
  end

  // Monitor: every response handshake is matched against the oldest expected entry.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rstN === 1'b1 && bus.rspValid === 1'b1 && bus.rspReady === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedRsp: got tag %0d, expected no response", bus.rspTag);
        end else begin
          e = sb.pop_front();
          checkOutput("rspData", bus.rspData, e.data);
          checkOutput("rspFlags", 64'({bus.rspCarry, bus.rspError, bus.rspTag}),
                      64'({e.carry, e.err, e.tag}));
          hsCount++;
          if (e.err) errHs++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    bit          seen;
    logic [3:0]  op;
    logic [63:0] a, b;
    int          legalOps[9] = '{0, 1, 2, 3, 7, 8, 9, 10, 12};

    rstN = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqOp    = '0;
    bus.reqA     = '0;
    bus.reqB     = '0;
    bus.reqTag   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReqReady", 64'(bus.reqReady), 64'd1);
    checkOutput("resetRspValid", 64'(bus.rspValid), 64'd0);
    checkOutput("resetAlu", 64'(bus.aluOp) | bus.aluFirst | bus.aluSecond, 64'd0);
    checkOutput("resetRsp", bus.rspData | 64'({bus.rspCarry, bus.rspError, bus.rspTag}), 64'd0);
    checkOutput("resetCounts", 64'({bus.opCount, bus.errCount}), 64'd0);
    releaseReset();
    repeat (2) @(posedge clk);

    $display("[TB] directed operations");
    applyStimulus(4'd0, 64'd5, 64'd7, 4'd3);
    waitValid(lat);
    checkOutput("addLatency", 64'(lat), 64'(SETTLE + 1));
    drain(50);
    applyStimulus(4'd0, '1, 64'd1, 4'd4);
    drain(50);
    applyStimulus(4'd7, 64'd11, 64'd22, 4'd5);
    drain(50);
    applyStimulus(4'd5, 64'd1, 64'd2, 4'd6);
    waitValid(lat);
    checkOutput("errLatency", 64'(lat), 64'd1);
    checkOutput("aluOpHeld", 64'(bus.aluOp), 64'd7);
    checkOutput("aluSecondHeld", bus.aluSecond, 64'd22);
    drain(50);
    applyStimulus(4'd3, 64'd9, 64'd0, 4'd7);
    drain(50);
    applyStimulus(4'd3, 64'd9, 64'd3, 4'd8);
    drain(50);
    applyStimulus(4'd1, 64'd1, 64'd2, 4'd9);
    drain(50);

    $display("[TB] backpressure");
    fixedReady = 1'b0;
    assertReset();
    releaseReset();
    repeat (2) @(posedge clk);
    for (int t = 0; t < 5; t++) applyStimulus(4'd7, 64'(t), 64'(100 + t), 4'(t));
    @(negedge clk);
    checkOutput("reqReadyFull", 64'(bus.reqReady), 64'd0);
    bus.reqOp    = 4'd7;
    bus.reqA     = 64'd5;
    bus.reqB     = 64'd105;
    bus.reqTag   = 4'd5;
    bus.reqValid = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("tag5Stalled", 64'(bus.reqReady), 64'd0);
    fixedReady = 1'b1;
    applyStimulus(4'd7, 64'd5, 64'd105, 4'd5);
    drain(100);
`ifdef ALU_DRV_STATS_EN
    checkOutput("opCountBp", 64'(bus.opCount), 64'd6);
`else
    checkOutput("opCountBp", 64'(bus.opCount), 64'd0);
`endif

    $display("[TB] randomized traffic");
    randReady = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(legalOps[$urandom_range(0, 8)]);
      a  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(1, 20));
      applyStimulus(op, a, b, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(3000);
    randReady = 1'b0;
    repeat (2) @(posedge clk);
`ifdef ALU_DRV_STATS_EN
    checkOutput("opCountRand", 64'(bus.opCount), 64'((hsCount > 65535) ? 65535 : hsCount));
    checkOutput("errCountRand", 64'(bus.errCount), 64'((errHs > 255) ? 255 : errHs));
`else
    checkOutput("opCountRand", 64'(bus.opCount), 64'd0);
    checkOutput("errCountRand", 64'(bus.errCount), 64'd0);
`endif

    $display("[TB] reset during settle");
    applyStimulus(4'd2, 64'd3, 64'd4, 4'd10);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mulIssued", 64'(bus.aluOp), 64'd2);
    @(posedge clk);
    #2 rstN = 1'b0;
    sb.delete();
    #1;
    checkOutput("midResetAlu", 64'(bus.aluOp) | bus.aluFirst | bus.aluSecond, 64'd0);
    checkOutput("midResetRsp", bus.rspData | 64'({bus.rspValid, bus.rspError, bus.rspTag}), 64'd0);
    checkOutput("midResetReqReady", 64'(bus.reqReady), 64'd1);
    releaseReset();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rspValid) seen = 1'b1;
    end
    checkOutput("noRspAfterReset", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential initiator for the 64-bit combinational ALU. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the ALU operand and opcode inputs, waits a fixed settle interval, then captures the result and carry and returns them with the request tag over a second valid/ready handshake. It sits between the datapath control and the ALU, and replaces direct combinational drive of the ALU inputs.

## Interface
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before the result is captured (minimum 1)
- FIFO_DEPTH, 4, request FIFO entries (power of two, minimum 2)
- clk  in  1  clock, rising edge
- rstN  in  1  reset, asynchronous, active-low
- reqValid  in  1  request valid
- reqReady  out  1  request ready; equals FIFO not full
- reqOp  in  4  ALU opcode
- reqA  in  64  first operand
- reqB  in  64  second operand
- reqTag  in  4  request tag, returned unchanged
- aluFirst  out  64  to ALU firstInput
- aluSecond  out  64  to ALU secondInput
- aluOp  out  4  to ALU operation
- aluResult  in  64  from ALU ALU_Out
- aluCarry  in  1  from ALU CarryOut
- rspValid  out  1  response valid
- rspReady  in  1  response ready
- rspData  out  64  captured result
- rspCarry  out  1  carry; meaningful for add only
- rspTag  out  4  tag of the request
- rspError  out  1  illegal opcode or divide by zero
- opCount  out  16  completed responses (ALU_DRV_STATS_EN)
- errCount  out  8  completed error responses (ALU_DRV_STATS_EN)

## Operation
- Legal opcodes:
  - 0000 add, 0001 sub, 0010 mul, 0011 div
  - 0111 pass B
  - 1000 and, 1001 or, 1010 xor, 1100 nor
  - All other opcodes are illegal.
- Push: a request is written into the FIFO on any edge where reqValid && reqReady. There is no pass-through from request to ALU when the FIFO is full.
- FSM states are IDLE, SETTLE and RESPOND.
- IDLE, FIFO non-empty: pop the head entry.
  - Legal opcode with no divide by zero: register the operands into aluFirst/aluSecond/aluOp, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - Illegal opcode, or opcode 0011 with B==0: do not drive the ALU (alu* outputs keep their previous values). Load rspData=0, rspCarry=0, rspError=1 and rspTag, go to RESPOND.
- SETTLE: the counter decrements each edge. On the edge where it reaches 0:
  - rspData<=aluResult
  - rspCarry<=aluCarry if aluOp==0000, else 0
  - rspError<=0, rspTag<=the held tag
  - go to RESPOND
- RESPOND: rspValid=1. All rsp* outputs stay stable until rspReady.
  - On the handshake edge, if the FIFO is non-empty, pop and process exactly as in IDLE on that same edge (back-to-back).
  - Otherwise go to IDLE.
- Width rules: mul keeps the low 64 bits. Sub and add wrap modulo 2^64. No sign handling is done in this block.
- Responses are returned strictly in request order.

## Timing
- Reset (rstN low, asynchronous):
  - FIFO emptied, FSM in IDLE
  - all alu* and rsp* outputs 0, rspValid 0, counters 0
  - reqReady 1
- Latency, legal op, empty pipeline: push on edge t0, pop/issue on t0+1, capture on t0+1+SETTLE_CYCLES. rspValid is high in the following cycle (t0+3 with the default).
- Latency, error op: rspValid is high after edge t0+1.
- Sustained throughput: one response per SETTLE_CYCLES+1 cycles when rspReady is held high.
- Push and pop on the same edge: both take effect, and occupancy is unchanged.
- A full FIFO drops reqReady in the cycle after the filling push.
- Reset mid-operation discards the in-flight request and all FIFO contents. No response is produced for them.

## Configuration
- ALU_DRV_STATS_EN defined:
  - opCount increments on every response handshake and saturates at 0xFFFF.
  - errCount increments on handshakes with rspError=1 and saturates at 0xFF.
  - Both counters clear on reset only.
- ALU_DRV_STATS_EN undefined: the ports still exist but are tied to 0, and no counter flops are built.

## Test plan
- Add: reset, push op 0000, A=5, B=7, tag 3, rspReady=1 -> rspValid 3 cycles after accept with rspData=12, rspCarry=0, rspTag=3, rspError=0.
- Add with carry: push op 0000, A=0xFFFFFFFFFFFFFFFF, B=1 -> rspData=0, rspCarry=1.
- Illegal opcode: push op 0101 -> rspValid 1 cycle after accept with rspError=1, rspData=0, and aluOp unchanged.
- Divide by zero: push op 0011, A=9, B=0 -> rspError=1, rspData=0. Then push op 0011, A=9, B=3 -> rspData=3, rspError=0.
- Backpressure: rspReady=0, push tags 0..5 -> tags 0..4 accepted, reqReady=0 after the 5th accept, tag 5 stalls. Release rspReady -> six responses in tag order 0..5. With the macro, opCount=6.
- Reset mid-SETTLE: push op 0010, A=3, B=4, pull rstN low 1 cycle after issue -> all outputs 0, reqReady=1, no response appears afterwards.
